// File: rtl/wb_sram_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : wb_sram_ctrl
// Brief   : Wishbone slave controller for asynchronous SRAM with configurable
//           width and wait states. Define WB_SRAM_CTRL_TURNAROUND_EN to add a
//           one-cycle bus turnaround between a read and a following write.
// Revision: 1.0 - initial release
// =============================================================================
module wb_sram_ctrl #(
  parameter int DW   = 16,
  parameter int AW   = 18,
  parameter int WAIT = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic              wb_we_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic [AW-1:0]     sram_addr_,
  inout  wire  [DW-1:0]     sram_data_,
  output logic              sram_ce_n_,
  output logic              sram_we_n_,
  output logic              sram_oe_n_,
  output logic [DW/8-1:0]   sram_bw_n_
);

  localparam int         NB     = DW / 8;
  localparam logic [3:0] C_WAIT = 4'(WAIT);

  generate
    if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
      $error("wb_sram_ctrl: WAIT=%0d is outside the legal range 1..15", WAIT);
    end
    if (DW != 8 && DW != 16 && DW != 32) begin : g_bad_dw
      $error("wb_sram_ctrl: DW=%0d must be 8, 16 or 32", DW);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TURN   = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            ack_q, ack_d;
  logic            ce_n_q, ce_n_d;
  logic            we_n_q, we_n_d;
  logic            oe_n_q, oe_n_d;
  logic [NB-1:0]   bw_n_q, bw_n_d;
  logic            drv_q, drv_d;
  logic            op;
  logic            access_done;
  logic            turn_req;

  assign op          = wb_cyc_i & wb_stb_i;
  assign access_done = (state_q == S_ACCESS) && (cnt_q == 4'd1);

`ifdef WB_SRAM_CTRL_TURNAROUND_EN
  logic last_rd_q, last_rd_d;

  // Remembers the direction of the last completed access so a write that
  // follows a read can give the SRAM output drivers a cycle to release.
  always_comb begin
    last_rd_d = last_rd_q;
    if (access_done) last_rd_d = ~we_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) last_rd_q <= 1'b0;
    else             last_rd_q <= last_rd_d;
  end

  assign turn_req = wb_we_i & last_rd_q;
`else
  assign turn_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    addr_d  = addr_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op) begin
          addr_d  = wb_adr_i;
          wdat_d  = wb_dat_i;
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
          cnt_d   = C_WAIT;
          state_d = turn_req ? S_TURN : S_ACCESS;
        end
      end
`ifdef WB_SRAM_CTRL_TURNAROUND_EN
      S_TURN: begin
        state_d = S_ACCESS;
      end
`endif
      S_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          if (!we_q) rdat_d = sram_data_;
          // An aborted cycle still runs to completion, just without an ack.
          ack_d = op;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pad strobes are registered, so they are decoded from the state being entered.
    ce_n_d = 1'b1;
    we_n_d = 1'b1;
    oe_n_d = 1'b1;
    bw_n_d = {NB{1'b1}};
    drv_d  = 1'b0;
    case (state_d)
      S_ACCESS: begin
        ce_n_d = 1'b0;
        bw_n_d = ~sel_d;
        we_n_d = ~we_d;
        oe_n_d = we_d;
        drv_d  = we_d;
      end
      S_ACK: begin
        ce_n_d = 1'b0;
        bw_n_d = ~sel_d;
        drv_d  = we_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= {NB{1'b0}};
      wdat_q  <= {DW{1'b0}};
      addr_q  <= {AW{1'b0}};
      rdat_q  <= {DW{1'b0}};
      ack_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      bw_n_q  <= {NB{1'b1}};
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      addr_q  <= addr_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      bw_n_q  <= bw_n_d;
      drv_q   <= drv_d;
    end
  end

  assign wb_dat_o   = rdat_q;
  assign wb_ack_o   = ack_q;
  assign sram_addr_ = addr_q;
  assign sram_ce_n_ = ce_n_q;
  assign sram_we_n_ = we_n_q;
  assign sram_oe_n_ = oe_n_q;
  assign sram_bw_n_ = bw_n_q;
  assign sram_data_ = drv_q ? wdat_q : {DW{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_wb_sram_ctrl
// Brief   : Directed scoreboard bench for wb_sram_ctrl (DW=32, WAIT=2) with a
//           behavioural SRAM on the pads.
// Revision: 1.0 - initial release
// =============================================================================
module tb_wb_sram_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 18;
  localparam int WAIT = 2;
  localparam int NB   = DW / 8;
`ifdef WB_SRAM_CTRL_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     wb_dat_i;
  logic [DW-1:0]     wb_dat_o;
  logic [AW-1:0]     wb_adr_i;
  logic              wb_we_i;
  logic [NB-1:0]     wb_sel_i;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic              wb_ack_o;
  logic [AW-1:0]     sram_addr;
  tri   [DW-1:0]     sram_data;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic [NB-1:0]     sram_bw_n;

  always #5 clk = ~clk;

  wb_sram_ctrl #(.DW(DW), .AW(AW), .WAIT(WAIT)) u_dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_adr_i   (wb_adr_i),
    .wb_we_i    (wb_we_i),
    .wb_sel_i   (wb_sel_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_ack_o   (wb_ack_o),
    .sram_addr_ (sram_addr),
    .sram_data_ (sram_data),
    .sram_ce_n_ (sram_ce_n),
    .sram_we_n_ (sram_we_n),
    .sram_oe_n_ (sram_oe_n),
    .sram_bw_n_ (sram_bw_n)
  );

  // An undriven bus floats to all ones, which makes hi-Z observable.
  for (genvar gi = 0; gi < DW; gi++) begin : g_pull
    pullup (sram_data[gi]);
  end

  function automatic logic [DW-1:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, b ^ 8'h5A, ~b, b + 8'd3};
  endfunction

  // Behavioural asynchronous SRAM, 256 words, indexed by the low address bits.
  logic [DW-1:0] sram_mem [256];
  logic [DW-1:0] sram_rd;
  bit            filled = 1'b0;
  assign sram_rd   = sram_mem[sram_addr[7:0]];
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_rd : {DW{1'bz}};

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
      filled <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < NB; b++)
        if (!sram_bw_n[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_data[8*b +: 8];
    end
  end

  int            vecs = 0;
  int            errs = 0;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q [$];
  bit            last_rd_m = 1'b0;
  logic [DW-1:0] last_rd_val = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer starting from IDLE; returns in the next IDLE cycle.
  task automatic xfer(input string tag, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [NB-1:0] s);
    int            n, we_lo, oe_lo, lat;
    bit            got, bw_ok, adr_ok, dat_ok, turn;
    logic          ce1;
    logic [DW-1:0] bus1, hold_v, dato_v;
    turn = we && last_rd_m && TURN_EN;
    lat  = WAIT + 1 + (turn ? 1 : 0);
    if (!we) exp_q.push_back(ref_mem[a[7:0]]);
    else for (int b = 0; b < NB; b++) if (s[b]) ref_mem[a[7:0]][8*b +: 8] = d[8*b +: 8];
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = s;
    n = 0; we_lo = 0; oe_lo = 0; got = 1'b0; bw_ok = 1'b1; adr_ok = 1'b1; dat_ok = 1'b1;
    ce1 = 1'bx; bus1 = 'x; hold_v = 'x; dato_v = 'x;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin ce1 = sram_ce_n; bus1 = sram_data; end
      if (!sram_we_n) begin we_lo++; if (sram_data !== d) dat_ok = 1'b0; end
      if (!sram_oe_n) oe_lo++;
      if (!sram_ce_n && sram_addr !== a) adr_ok = 1'b0;
      if (!sram_we_n || !sram_oe_n) if (sram_bw_n !== ~s) bw_ok = 1'b0;
      if (wb_ack_o) begin got = 1'b1; hold_v = sram_data; dato_v = wb_dat_o; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check({tag, ".ack_latency"}, n, lat);
    check({tag, ".we_n_low_cycles"}, we_lo, we ? WAIT : 0);
    check({tag, ".oe_n_low_cycles"}, oe_lo, we ? 0 : WAIT);
    check({tag, ".bw_n_lanes"}, bw_ok, 1);
    check({tag, ".sram_addr"}, adr_ok, 1);
    check({tag, ".ce_n_first_cycle"}, ce1, turn ? 1'b1 : 1'b0);
    if (we) begin
      check({tag, ".wr_data_on_bus"}, dat_ok, 1);
      check({tag, ".bus_first_cycle"}, bus1, turn ? {DW{1'b1}} : d);
      check({tag, ".wr_hold_data"}, hold_v, d);
      check({tag, ".dat_o_held"}, dato_v, last_rd_val);
    end else begin
      check({tag, ".bus_hiz_in_ack"}, hold_v, {DW{1'b1}});
      if (got) begin
        last_rd_val = exp_q.pop_front();
        check({tag, ".rd_data"}, dato_v, last_rd_val);
      end
    end
    last_rd_m = !we;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed run still active, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, oe_lo, n, last, extra;
    bit gap_ok;
    logic ce_ack, ce_idle;
    logic [AW-1:0] base;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    repeat (3) @(negedge clk);
    check("reset.ack", wb_ack_o, 0);
    check("reset.dat_o", wb_dat_o, 0);
    check("reset.addr", sram_addr, 0);
    check("reset.strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
    check("reset.bw_n", sram_bw_n, {NB{1'b1}});
    check("reset.bus_hiz", sram_data, {DW{1'b1}});
    rst_n = 1'b1;
    @(negedge clk);

    xfer("wr_beef", 1'b1, 18'h00123, 32'h0000BEEF, 4'b1111);
    xfer("rd_beef", 1'b0, 18'h00123, '0, 4'b1111);
    // Write straight after a read: exercises the turnaround when built in.
    xfer("wr_lane2", 1'b1, 18'h00040, 32'h11223344, 4'b0100);
    xfer("rd_lane2", 1'b0, 18'h00040, '0, 4'b1111);
    xfer("wr_a", 1'b1, 18'h00041, 32'hCAFE0001, 4'b0011);
    xfer("wr_b", 1'b1, 18'h00042, 32'h5AA5C33C, 4'b1001);
    xfer("rd_b", 1'b0, 18'h00042, '0, 4'b1111);

    // Master abandons a read after its first ACCESS cycle.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 18'h00055; wb_sel_i = '1;
    @(negedge clk);
    oe_lo = sram_oe_n ? 0 : 1;
    acks = wb_ack_o ? 1 : 0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ce_ack = 1'bx; ce_idle = 1'bx;
    for (int k = 2; k <= WAIT + 4; k++) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
      if (!sram_oe_n) oe_lo++;
      if (k == WAIT + 1) ce_ack = sram_ce_n;
      if (k == WAIT + 2) ce_idle = sram_ce_n;
    end
    check("abort.no_ack", acks, 0);
    check("abort.oe_n_low_cycles", oe_lo, WAIT);
    check("abort.ce_n_in_ack", ce_ack, 1'b0);
    check("abort.ce_n_idle", ce_idle, 1'b1);
    last_rd_m = 1'b1;
    last_rd_val = ref_mem[8'h55];
    xfer("rd_after_abort", 1'b0, 18'h00056, '0, 4'b1111);

    // Reset asserted in the middle of a write.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 18'h00077;
    wb_dat_i = 32'hA5A5A5A5; wb_sel_i = '1;
    @(negedge clk);
    check("rst_mid.in_access_we_n", sram_we_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
    check("rst_mid.bw_n", sram_bw_n, {NB{1'b1}});
    check("rst_mid.ack", wb_ack_o, 1'b0);
    check("rst_mid.bus_hiz", sram_data, {DW{1'b1}});
    check("rst_mid.dat_o", wb_dat_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (WAIT + 3) begin @(negedge clk); if (wb_ack_o) acks++; end
    check("rst_mid.no_ack_after", acks, 0);
    last_rd_m = 1'b0;
    last_rd_val = '0;
    xfer("rd_after_rst", 1'b0, 18'h00123, '0, 4'b1111);

    // Strobe held for eight consecutive reads.
    base = 18'h00080;
    exp_q.push_back(ref_mem[base[7:0]]);
    wb_adr_i = base; wb_we_i = 1'b0; wb_sel_i = '1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    acks = 0; n = 0; last = 0; gap_ok = 1'b1;
    while (acks < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (wb_ack_o) begin
        acks++;
        check($sformatf("thru.rd%0d", acks), wb_dat_o, exp_q.pop_front());
        if (n - last != ((acks == 1) ? WAIT + 1 : WAIT + 2)) gap_ok = 1'b0;
        last = n;
        if (acks < 8) begin
          wb_adr_i = base + AW'(acks);
          exp_q.push_back(ref_mem[wb_adr_i[7:0]]);
        end
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("thru.ack_count", acks, 8);
    check("thru.ack_spacing", gap_ok, 1);
    extra = 0;
    repeat (WAIT + 3) begin @(negedge clk); if (wb_ack_o) extra++; end
    check("thru.no_extra_ack", extra, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_sram_ctrl.md
# wb_sram_ctrl

Parametrised Wishbone-slave controller for asynchronous SRAM. It is the next-generation replacement for the fixed 16-bit single-cycle SRAM bridge. It adds configurable data width, address width and access wait states, plus an explicit access state machine with write hold, cycle-abort handling and an optional read-to-write bus turnaround. It sits between the system Wishbone interconnect and the board SRAM pads.

## Interface
- DW, 16: data width in bits; must be 8, 16 or 32. Byte lanes NB = DW/8.
- AW, 18: SRAM word-address width.
- WAIT, 2: SRAM access cycles per transfer; legal range 1..15.

- wb_clk_i  in  1  system clock. One clock; all logic on its rising edge.
- wb_rst_n_i  in  1  reset. Asynchronous assert, active-low.
- wb_dat_i  in  DW  write data.
- wb_dat_o  out  DW  read data, registered.
- wb_adr_i  in  AW  word address.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  NB  byte selects.
- wb_stb_i, wb_cyc_i  in  1 each  strobe and cycle.
- wb_ack_o  out  1  acknowledge, registered, one-cycle pulse.
- sram_addr_  out  AW  SRAM address, registered.
- sram_data_  inout  DW  SRAM data pads; driven only when the internal drive enable is set, otherwise hi-Z.
- sram_ce_n_, sram_we_n_, sram_oe_n_  out  1 each  SRAM chip enable, write strobe and output enable, all active-low and registered.
- sram_bw_n_  out  NB  SRAM byte writes, active-low, registered.

## Operation
- op = wb_cyc_i & wb_stb_i.
- States: IDLE, TURN (macro only), ACCESS, ACK.
- **IDLE**
  - All pad strobes are high and the data bus is hi-Z.
  - When op is sampled high, latch address, write data, ~sel and we into the pad registers.
  - Load the wait counter with WAIT, then go to ACCESS (or to TURN, see Configuration).
- **ACCESS**
  - ce_n=0 and bw_n=~sel.
  - Write: we_n=0, oe_n=1, data driven.
  - Read: we_n=1, oe_n=0, data hi-Z.
  - The counter decrements each cycle. On the edge where counter==1:
    - on a read, sample sram_data_ into wb_dat_o;
    - go to ACK.
- **ACK**
  - we_n=1, oe_n=1, ce_n=0.
  - On a write, data stays driven for one hold cycle.
  - wb_ack_o is high during this state only if op was sampled high on the edge that entered ACK.
  - If op was low on that edge (the master aborted), the SRAM cycle still completes and wb_ack_o stays low.
  - Next state is IDLE unconditionally.
- Master-side changes to wb_adr_i, wb_dat_i or wb_we_i during ACCESS are ignored; the latched values are used.
- wb_dat_o holds its last read value through writes and idle cycles.
- The last_rd flag is set after a read completes and cleared after a write completes.

## Timing
- Edge 0 samples op in IDLE; pad strobes are active from edge 0.
- ACCESS occupies WAIT cycles.
- wb_ack_o is high in the cycle after edge WAIT.
- Back to IDLE at edge WAIT+1.
- Minimum transfer period is WAIT+2 cycles. The mandatory IDLE cycle between transfers guarantees strobe deassertion.
- Read data is sampled at the end of the last ACCESS cycle, i.e. WAIT cycles after oe_n falls.
- On wb_rst_n_i low, immediately and asynchronously:
  - state=IDLE;
  - wb_ack_o=0, wb_dat_o=0, sram_addr_=0;
  - ce_n=1, we_n=1, oe_n=1, bw_n=all ones;
  - drive enable=0 (bus hi-Z), last_rd=0.
- Reset mid-access abandons the transfer. No ack is ever produced for it.
- A WAIT value outside 1..15 is a configuration error. The implementation flags it with an elaboration-time check.

## Configuration
- Macro: WB_SRAM_CTRL_TURNAROUND_EN.
- **Defined:** when IDLE accepts a write and last_rd=1, the controller enters TURN for exactly one cycle before ACCESS.
  - In TURN, all strobes are high and the bus is hi-Z.
  - Ack latency for that write becomes WAIT+2 cycles.
  - Reads, and writes following writes, are unaffected.
- **Undefined:** the TURN state and the last_rd flag are not built. IDLE always goes directly to ACCESS.

## Test plan
- **Reset values:** assert wb_rst_n_i mid-ACCESS of a write → strobes high, bus hi-Z and ack 0 asynchronously; no ack after release.
- **Write then read (DW=16, WAIT=2):** write 0xBEEF to addr 0x00123 with sel=2'b11 → we_n low for 2 cycles, ack 3 cycles after the op edge. Then read 0x00123 → wb_dat_o=0xBEEF coincident with ack.
- **Byte lane (DW=32):** write 0x11223344 with sel=4'b0100 → sram_bw_n_=4'b1011; a read back returns only lane 2 updated (0x22).
- **Abort:** drop wb_cyc_i after the first ACCESS cycle of a read → SRAM cycle completes, no ack, FSM back in IDLE at edge WAIT+1.
- **Turnaround (macro defined, WAIT=1):** read followed by back-to-back write → one cycle with strobes high and bus hi-Z between oe_n rising and write data driven; write ack 3 cycles after the op edge. Without the macro: ack at 2 cycles.
- **Throughput (WAIT=1):** hold stb for 8 consecutive reads → ack every 3rd cycle, exactly 8 ack pulses, addresses in order.
